// File: rtl/dx_hazard_latch.sv
// dx_hazard_latch
//   D/X pipeline latch with hazard control. It sits between decode and
//   execute and provides irDX/pcDX to the bypass unit and the execute stage.
//   It inserts a one-cycle bubble on load-use hazards, holds the pipeline
//   while the multi-cycle mult/div unit runs, and squashes the D/X slot
//   when a taken branch/jump resolves in X.
//
// Parameters
//   MD_TIMEOUT  cycles allowed in MD_WAIT before a forced release (>= 2)
//   CNT_W       width of stall_count
//
// Optional feature
//   STALL_COUNT_EN  when defined, adds the stall_count output and a
//                   saturating counter of cycles with stallFD=1.
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   irFD        in   [31:0] instruction in the F/D latch
//   pcFD        in   [31:0] PC+1 of irFD
//   flush       in   taken branch/jump resolved in X this cycle
//   md_ready    in   mult/div result valid this cycle
//   irDX        out  [31:0] registered D/X instruction (0 = nop)
//   pcDX        out  [31:0] registered D/X PC
//   stallFD     out  combinational; 1 = hold PC and the F/D latch
//   md_start    out  registered 1-cycle pulse: start mult/div on irDX
//   md_busy     out  registered; 1 while waiting on mult/div
//   md_timeout  out  registered 1-cycle pulse on a forced MD_WAIT exit
//   stall_count out  [CNT_W-1:0] saturating stall count (STALL_COUNT_EN)

module dx_hazard_latch #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] irFD,
  input  logic [31:0] pcFD,
  input  logic        flush,
  input  logic        md_ready,
  output logic [31:0] irDX,
  output logic [31:0] pcDX,
  output logic        stallFD,
  output logic        md_start,
  output logic        md_busy,
  output logic        md_timeout
`ifdef STALL_COUNT_EN
  ,
  output logic [CNT_W-1:0] stall_count
`endif
);

  localparam int TIMER_W = $clog2(MD_TIMEOUT);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic {
    IDLE,
    MD_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [31:0]        irDX_q, irDX_d;
  logic [31:0]        pcDX_q, pcDX_d;
  logic               mdStart_q, mdStart_d;
  logic               mdBusy_q, mdBusy_d;
  logic               mdTimeout_q, mdTimeout_d;

  logic [4:0] opFD, rsFD, rtFD, rdFD, aluFD;
  logic [4:0] opDX, rdDX;
  logic       loadUse;
  logic       fdIsMd;
  logic       toHit;
  logic       accept;

  assign opFD  = irFD[31:27];
  assign rdFD  = irFD[26:22];
  assign rsFD  = irFD[21:17];
  assign rtFD  = irFD[16:12];
  assign aluFD = irFD[6:2];
  assign opDX  = irDX_q[31:27];
  assign rdDX  = irDX_q[26:22];

  // Remaining instruction bits carry nothing this block decodes.
  logic unusedFdBits;
  assign unusedFdBits = ^{irFD[11:7], irFD[1:0]};

  // A load into $0 never produces a value, so it cannot create a hazard.
  // Stores read their data register from the rd field.
  assign loadUse = (opDX == OP_LW) && (rdDX != 5'd0) &&
                   ((rsFD == rdDX) ||
                    ((opFD == OP_RTYPE) && (rtFD == rdDX)) ||
                    ((opFD == OP_SW) && (rdFD == rdDX)));

  assign fdIsMd = (opFD == OP_RTYPE) && ((aluFD == ALU_MUL) || (aluFD == ALU_DIV));

  // Last permitted MD_WAIT cycle; the wait is released on this edge.
  assign toHit = (timer_q == TIMER_W'(MD_TIMEOUT - 1));

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      irDX_q      <= '0;
      pcDX_q      <= '0;
      mdStart_q   <= 1'b0;
      mdBusy_q    <= 1'b0;
      mdTimeout_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      irDX_q      <= irDX_d;
      pcDX_q      <= pcDX_d;
      mdStart_q   <= mdStart_d;
      mdBusy_q    <= mdBusy_d;
      mdTimeout_q <= mdTimeout_d;
    end
  end

  // Next-state logic. 'accept' means irFD is taken into D/X this edge;
  // it is shared by the IDLE path and the MD_WAIT release path.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    irDX_d      = irDX_q;
    pcDX_d      = pcDX_q;
    mdStart_d   = 1'b0;
    mdBusy_d    = mdBusy_q;
    mdTimeout_d = 1'b0;
    accept      = 1'b0;

    case (state_q)
      IDLE: begin
        if (flush || loadUse) begin
          irDX_d = '0;
          pcDX_d = '0;
        end else begin
          accept = 1'b1;
        end
      end
      MD_WAIT: begin
        // Flush is ignored here: the branch in X cannot advance while
        // the pipeline is held.
        timer_d = timer_q + TIMER_W'(1);
        if (md_ready || toHit) begin
          accept      = 1'b1;
          mdTimeout_d = !md_ready;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      irDX_d = irFD;
      pcDX_d = pcFD;
      if (fdIsMd) begin
        state_d   = MD_WAIT;
        timer_d   = '0;
        mdStart_d = 1'b1;
        mdBusy_d  = 1'b1;
      end else begin
        state_d  = IDLE;
        mdBusy_d = 1'b0;
      end
    end
  end

  // Output logic
  always_comb begin
    stallFD = ((state_q == IDLE) && loadUse && !flush) ||
              ((state_q == MD_WAIT) && !md_ready && !toHit);
  end

  assign irDX       = irDX_q;
  assign pcDX       = pcDX_q;
  assign md_start   = mdStart_q;
  assign md_busy    = mdBusy_q;
  assign md_timeout = mdTimeout_q;

`ifdef STALL_COUNT_EN
  logic [CNT_W-1:0] stallCount_q;

  // Saturates instead of wrapping; only reset clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      stallCount_q <= '0;
    end else if (stallFD && (stallCount_q != {CNT_W{1'b1}})) begin
      stallCount_q <= stallCount_q + CNT_W'(1);
    end
  end

  assign stall_count = stallCount_q;
`else
  logic [CNT_W-1:0] unusedCountWidth;
  assign unusedCountWidth = '0;
`endif

endmodule
